fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each requester word and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of write requesters (legal range 2..8).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum accepted words per grant (legal range 1..16).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester word-valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester word accepted this cycle.
REQ-009 SHALL have port fifo_din  output  DATA_WIDTH  FIFO write data.
REQ-010 SHALL have port fifo_write  output  1  FIFO write strobe.
REQ-011 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-012 SHALL have port fifo_alf  input  1  FIFO almost-full flag.
REQ-013 SHALL have port grant  output  NUM_REQ  one-hot current owner; all zero when none.
REQ-014 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-016 In IDLE, with any req_valid high and fifo_alf low, the FSM SHALL select the first requester with req_valid high, searching upward from rr_ptr with wrap, and enter GRANT next cycle with grant one-hot on that requester and beat_cnt = 0.
REQ-017 In IDLE with fifo_alf high, the FSM SHALL issue no grant.
REQ-018 A transfer SHALL occur in any cycle where grant[i], req_valid[i] and !fifo_full all hold; transfer requires both valid and ready.
REQ-019 req_ready[i] SHALL equal grant[i] & !fifo_full, combinationally.
REQ-020 fifo_write SHALL equal the transfer condition and fifo_din SHALL equal the owner's req_data, both combinationally, giving zero-cycle latency from accept to FIFO write.
REQ-021 fifo_din SHALL be all zero when grant is all zero.
REQ-022 beat_cnt SHALL increment by 1 per transfer and SHALL hold while fifo_full is high.
REQ-023 GRANT SHALL return to IDLE after the transfer that brings beat_cnt to BURST_LEN.
REQ-024 GRANT SHALL return to IDLE in any cycle where the owner's req_valid is low.
REQ-025 On return to IDLE, rr_ptr SHALL be set to (owner+1) mod NUM_REQ and grant SHALL clear.
REQ-026 Exactly one IDLE bubble cycle SHALL separate consecutive grants.
REQ-027 fifo_alf rising during GRANT SHALL NOT end the burst; only fifo_full stalls it.
REQ-028 fifo_write SHALL never be high while fifo_full is high.
REQ-029 Non-owner req_ready SHALL be 0 at all times.

Reset
REQ-030 When reset is low, the block SHALL immediately force state=IDLE, grant=0, beat_cnt=0 and rr_ptr=0; as a consequence req_ready=0, fifo_write=0, fifo_din=0 and busy=0.
REQ-031 A reset asserted mid-burst SHALL discard the remainder of the burst with no FIFO write in the reset cycle; after release, requester 0 SHALL have first priority.

Structure
REQ-032 A shared package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the default DATA_WIDTH, NUM_REQ and BURST_LEN constants.
REQ-033 The rotating-priority selection SHALL be a combinational sub-module rr_pick with inputs req_valid and rr_ptr, and a one-hot output.

Verification
REQ-034 Requester 0 only, words 0x10..0x15 held valid, FIFO empty -> grant after 1 cycle, 4 writes, 1 IDLE cycle, regrant, 2 writes; FIFO contents 0x10..0x15 in order.
REQ-035 All 4 requesters continuously valid -> grant order 0,1,2,3,0, each grant exactly 4 writes, 1-cycle bubble between grants.
REQ-036 fifo_full high for 3 cycles after beat 2 -> fifo_write=0 and req_ready=0 for those 3 cycles, beat_cnt holds at 2, then 2 more writes, then release.
REQ-037 fifo_alf=1 in IDLE with req_valid=4'b0010 -> no grant; fifo_alf drops -> grant=4'b0010 next cycle.
REQ-038 Owner 2 drops req_valid after 1 write -> IDLE next cycle, rr_ptr=3; requesters 0 and 3 then pending -> requester 3 granted.
REQ-039 Reset driven low during beat 3 of a burst -> grant=0, fifo_write=0 immediately; after release with all requesters valid -> requester 0 granted first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
//   arb_state_e   : arbiter FSM state (IDLE, GRANT)
//   DEF_*         : default DATA_WIDTH / NUM_REQ / BURST_LEN
//   idx_width()   : bits needed to index NUM_REQ requesters (min 1)
package fifo_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_BURST_LEN  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: one-hot select of the first valid requester,
// searching upward from rr_ptr and wrapping at NUM_REQ.
//   req_valid : per-requester valid
//   rr_ptr    : index with highest priority this cycle
//   pick      : one-hot winner, all zero when nothing is valid
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] pick
);

  // One extra bit so rr_ptr + k never overflows before the wrap subtract.
  logic [IW:0] cand;
  logic        found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req_valid[IW'(cand)]) begin
        pick[IW'(cand)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ word streams into one FIFO
// write port. A grant lasts up to BURST_LEN accepted words, ends early when
// the owner drops valid, and is always followed by one IDLE cycle.
// req_ready / fifo_write / fifo_din are combinational from the registered
// grant so an accepted word reaches the FIFO in the same cycle.
//   clk, reset      : clock, asynchronous active-low reset
//   req_valid/data  : per-requester word and valid (packed, i*DATA_WIDTH)
//   req_ready       : per-requester accept strobe
//   fifo_din/write  : FIFO write data and strobe
//   fifo_full/alf   : FIFO full (stalls burst) / almost-full (blocks grant)
//   grant           : one-hot current owner
//   busy            : high in GRANT
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_write,
  input  logic                          fifo_full,
  input  logic                          fifo_alf,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  arb_state_e         state;
  logic [BW-1:0]      beat_cnt;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] pick;
  logic               owner_valid;
  logic               xfer;
  logic               last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .pick      (pick)
  );

  // Binary index of the picked requester, stored so the data mux stays small.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  assign owner_valid = (state == GRANT) & req_valid[owner];
  assign xfer        = owner_valid & ~fifo_full;
  assign last_beat   = (beat_cnt == BW'(BURST_LEN - 1));
  assign next_ptr    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  assign req_ready  = grant & {NUM_REQ{~fifo_full}};
  assign fifo_write = xfer;
  assign fifo_din   = (|grant) ? req_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH]
                               : '0;
  assign busy       = (state == GRANT);

  // Arbiter FSM; grant is the registered owner vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req_valid) && !fifo_alf) begin
            state    <= GRANT;
            grant    <= pick;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + BW'(1);
          // Owner went quiet, or this accept completes the burst.
          if (!owner_valid || (xfer && last_beat)) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
